// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock / staggered core-reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        LOSS
    } seq_state_t;

    localparam int unsigned CNT_W = 8;

    // Ceiling log2, never below 1 so the result can always size a vector.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop bit synchronizer; each bit is treated independently, reset to 0.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_reset_seq.sv
// PLL reset / lock supervisor: pulses the PLL reset, waits for stable lock and
// releases the per-domain core resets one by one in ascending order.
module pll_lock_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS   = 5,
    parameter int unsigned RST_PULSE     = 16,
    parameter int unsigned LOCK_TIMEOUT  = 1000000,
    parameter int unsigned STABLE_CYCLES = 4096,
    parameter int unsigned STAGGER       = 256
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   pll_locked,
    input  logic                   soft_reset_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] core_reset_n,
    output logic                   ready,
    output logic [CNT_W-1:0]       lock_loss_cnt,
    output logic [CNT_W-1:0]       retry_cnt
);

    localparam int unsigned MAX_AB  = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
    localparam int unsigned MAX_CD  = (STABLE_CYCLES > STAGGER) ? STABLE_CYCLES : STAGGER;
    localparam int unsigned MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned TW      = clog2(MAX_ALL);
    localparam int unsigned IW      = clog2(NUM_DOMAINS);

    localparam logic [TW-1:0] RST_LAST     = TW'(RST_PULSE - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] STAGGER_LAST = TW'(STAGGER - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DOMAINS - 1);

    seq_state_t             state, state_nxt;
    logic [TW-1:0]          timer, timer_nxt;
    logic [IW-1:0]          idx, idx_nxt;
    logic                   pll_rst_nxt;
    logic [NUM_DOMAINS-1:0] core_nxt;
    logic                   ready_nxt;
    logic [CNT_W-1:0]       loss_nxt, retry_nxt;
    logic                   lk;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (pll_locked),
        .q      (lk)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= PLL_RST;
            timer         <= '0;
            idx           <= '0;
            pll_rst       <= 1'b1;
            core_reset_n  <= '0;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
            retry_cnt     <= '0;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            idx           <= idx_nxt;
            pll_rst       <= pll_rst_nxt;
            core_reset_n  <= core_nxt;
            ready         <= ready_nxt;
            lock_loss_cnt <= loss_nxt;
            retry_cnt     <= retry_nxt;
        end
    end

    // Outputs are computed alongside the next state so they change on the same edge.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer + 1'b1;
        idx_nxt     = idx;
        pll_rst_nxt = pll_rst;
        core_nxt    = core_reset_n;
        ready_nxt   = ready;
        loss_nxt    = lock_loss_cnt;
        retry_nxt   = retry_cnt;

        if (soft_reset_req) begin
            state_nxt   = PLL_RST;
            timer_nxt   = '0;
            pll_rst_nxt = 1'b1;
            core_nxt    = '0;
            ready_nxt   = 1'b0;
        end else begin
            case (state)
                PLL_RST: begin
                    if (timer == RST_LAST) begin
                        state_nxt   = WAIT_LOCK;
                        timer_nxt   = '0;
                        pll_rst_nxt = 1'b0;
                    end
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        state_nxt = STABLE;
                        timer_nxt = '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        state_nxt   = PLL_RST;
                        timer_nxt   = '0;
                        pll_rst_nxt = 1'b1;
                        retry_nxt   = sat_inc(retry_cnt);
                    end
                end
                STABLE: begin
                    if (!lk) begin
                        state_nxt = WAIT_LOCK;
                        timer_nxt = '0;
                    end else if (timer == STABLE_LAST) begin
                        timer_nxt = '0;
                        idx_nxt   = '0;
                        core_nxt  = NUM_DOMAINS'(1);
                        if (NUM_DOMAINS == 1) begin
                            state_nxt = RUN;
                            ready_nxt = 1'b1;
                        end else begin
                            state_nxt = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (!lk) begin
                        state_nxt = LOSS;
                        timer_nxt = '0;
                        core_nxt  = '0;
                    end else if (timer == STAGGER_LAST) begin
                        timer_nxt = '0;
                        idx_nxt   = idx + 1'b1;
                        // Shifting in a 1 releases exactly the next-higher domain.
                        core_nxt  = core_reset_n | (core_reset_n << 1);
                        if (idx_nxt == IDX_LAST) begin
                            state_nxt = RUN;
                            ready_nxt = 1'b1;
                        end
                    end
                end
                RUN: begin
                    timer_nxt = '0;
                    if (!lk) begin
                        state_nxt = LOSS;
                        core_nxt  = '0;
                        ready_nxt = 1'b0;
                        loss_nxt  = sat_inc(lock_loss_cnt);
                    end
                end
                default: begin
                    state_nxt   = PLL_RST;
                    timer_nxt   = '0;
                    pll_rst_nxt = 1'b1;
                    core_nxt    = '0;
                    ready_nxt   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Scoreboard bench: stimulus queues expected output changes with their cycle; a monitor checks each change.
module tb_pll_lock_reset_seq;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       soft_reset_req = 1'b0;
    logic       pll_rst;
    logic [4:0] core_reset_n;
    logic       ready;
    logic [7:0] lock_loss_cnt;
    logic [7:0] retry_cnt;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int          at;
        logic [22:0] val;
    } exp_t;

    exp_t sb[$];

    pll_lock_reset_seq #(
        .NUM_DOMAINS  (5),
        .RST_PULSE    (4),
        .LOCK_TIMEOUT (50),
        .STABLE_CYCLES(8),
        .STAGGER      (3)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .soft_reset_req(soft_reset_req),
        .pll_rst       (pll_rst),
        .core_reset_n  (core_reset_n),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt),
        .retry_cnt     (retry_cnt)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int at, input logic pr, input logic [4:0] core, input logic rdy,
                        input logic [7:0] loss, input logic [7:0] retry);
        exp_t e;
        e.at  = at;
        e.val = {pr, core, rdy, loss, retry};
        sb.push_back(e);
    endtask

    // Full lock-to-RUN sequence starting from PLL_RST with timer 0 after edge 'base'.
    task automatic push_seq(input int base, input int rel, input logic [7:0] loss, input logic [7:0] retry);
        logic [4:0] core;
        push(base + 4, 1'b0, 5'b00000, 1'b0, loss, retry);
        core = '0;
        for (int i = 0; i < 5; i++) begin
            core = {core[3:0], 1'b1};
            push(base + rel + 3 * i, 1'b0, core, (i == 4), loss, retry);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            $display("FAIL drain_timeout: %0d expected output changes not seen, required 0", sb.size());
            errors = errors + sb.size();
            checks = checks + sb.size();
            sb.delete();
        end
        repeat (10) @(negedge clk);
    endtask

    initial begin : monitor
        logic [22:0] prev;
        logic [22:0] cur;
        exp_t        e;
        prev = 'x;
        forever begin
            @(negedge clk or negedge reset_n);
            #1;
            cur = {pll_rst, core_reset_n, ready, lock_loss_cnt, retry_cnt};
            if (cur !== prev) begin
                prev = cur;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got rst=%b core=%b rdy=%b loss=%0d retry=%0d at cyc %0d, required no change",
                             cur[22], cur[21:17], cur[16], cur[15:8], cur[7:0], cyc);
                end else begin
                    e = sb.pop_front();
                    if (cur !== e.val || cyc != e.at) begin
                        errors++;
                        $display("FAIL out_change: got rst=%b core=%b rdy=%b loss=%0d retry=%0d at cyc %0d, required rst=%b core=%b rdy=%b loss=%0d retry=%0d at cyc %0d",
                                 cur[22], cur[21:17], cur[16], cur[15:8], cur[7:0], cyc,
                                 e.val[22], e.val[21:17], e.val[16], e.val[15:8], e.val[7:0], e.at);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int c;
        int base;
        int r;
        pll_locked = 1'b1;

        // Power-on reset with lock already present.
        push(0, 1'b1, 5'b00000, 1'b0, 8'd0, 8'd0);
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        c = cyc;
        push_seq(c, 13, 8'd0, 8'd0);
        reset_n = 1'b1;
        wait_drain(200);

        // Lock lost in RUN, then held low long enough for retry_cnt to saturate.
        c = cyc;
        push(c + 3, 1'b0, 5'b00000, 1'b0, 8'd1, 8'd0);
        push(c + 4, 1'b1, 5'b00000, 1'b0, 8'd1, 8'd0);
        push(c + 8, 1'b0, 5'b00000, 1'b0, 8'd1, 8'd0);
        for (int k = 1; k <= 257; k++) begin
            push(c + 4 + 54 * k, 1'b1, 5'b00000, 1'b0, 8'd1, (k > 255) ? 8'd255 : 8'(k));
            if (k < 257)
                push(c + 8 + 54 * k, 1'b0, 5'b00000, 1'b0, 8'd1, (k > 255) ? 8'd255 : 8'(k));
        end
        pll_locked = 1'b0;
        r = c + 4 + 54 * 257;
        wait_cyc(r);
        pll_locked = 1'b1;
        push_seq(r, 13, 8'd1, 8'd255);
        wait_drain(20000);

        // Soft reset pulse in RUN, then a held soft reset mid-RELEASE.
        c = cyc;
        base = c + 1;
        push(base, 1'b1, 5'b00000, 1'b0, 8'd1, 8'd255);
        push(base + 4, 1'b0, 5'b00000, 1'b0, 8'd1, 8'd255);
        push(base + 13, 1'b0, 5'b00001, 1'b0, 8'd1, 8'd255);
        push(base + 16, 1'b0, 5'b00011, 1'b0, 8'd1, 8'd255);
        soft_reset_req = 1'b1;
        @(negedge clk);
        soft_reset_req = 1'b0;
        wait_cyc(base + 17);
        push(base + 18, 1'b1, 5'b00000, 1'b0, 8'd1, 8'd255);
        soft_reset_req = 1'b1;
        wait_cyc(base + 20);
        soft_reset_req = 1'b0;
        push_seq(base + 20, 13, 8'd1, 8'd255);
        wait_drain(200);

        // Asynchronous reset in RUN, away from any clock edge.
        c = cyc;
        #2;
        push(c, 1'b1, 5'b00000, 1'b0, 8'd0, 8'd0);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        c = cyc;
        push_seq(c, 13, 8'd0, 8'd0);
        reset_n = 1'b1;
        wait_drain(200);

        // Soft reset on the same edge lk falls, then a one-cycle lock glitch in STABLE.
        c = cyc;
        pll_locked = 1'b0;
        push(c + 3, 1'b1, 5'b00000, 1'b0, 8'd0, 8'd0);
        repeat (2) @(negedge clk);
        soft_reset_req = 1'b1;
        @(negedge clk);
        soft_reset_req = 1'b0;
        pll_locked = 1'b1;
        base = c + 3;
        push_seq(base, 20, 8'd0, 8'd0);
        wait_cyc(base + 8);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        wait_drain(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
